// File: rtl/bk_sector_streamer_pkg.sv
// Shared types for the backup sector streamer: FSM state and transfer direction.
package bk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2,
        XFER = 2'd3
    } bk_state_t;

    typedef enum logic {
        DIR_SAVE = 1'b0,
        DIR_LOAD = 1'b1
    } bk_dir_t;

endpackage

// File: rtl/bk_sector_streamer_if.sv
// SD block handshake between the sector streamer (master) and hps_io (slave).
// One rd/wr request per sector; ack is held high for the duration of the sector.
interface bk_sector_streamer_if #(
    parameter int LBA_W = 32
);
    logic [LBA_W-1:0] sd_lba;
    logic             sd_rd;
    logic             sd_wr;
    logic             sd_ack;

    modport master (output sd_lba, sd_rd, sd_wr, input sd_ack);
    modport slave  (input sd_lba, sd_rd, sd_wr, output sd_ack);
endinterface

// File: rtl/bk_sector_streamer_timeout.sv
// Saturating acknowledge timeout: expired is high on the (2^TMO_W-1)th enabled cycle since clear.
// Counter holds at all ones; clear has priority over enable.
module bk_timeout #(
    parameter int TMO_W = 20
) (
    input  logic clk_sys,
    input  logic RESET_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam logic [TMO_W-1:0] LAST = TMO_W'((2 ** TMO_W) - 2);

    logic [TMO_W-1:0] cnt;

    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + TMO_W'(1);
        end
    end

    // cnt counts completed cycles, so the current enabled cycle is the (cnt+1)th
    assign expired = en && (cnt >= LAST);

endmodule

// File: rtl/bk_sector_streamer.sv
// Streams 2^SECT_BITS sectors of a backup slot over sd_rd/sd_wr with ack timeout, retry and abort.
// Request edge to first rd/wr: 2 cycles; ack stalls are absorbed by the per-sector timeout.
module bk_sector_streamer
    import bk_pkg::*;
#(
    parameter int               SECT_BITS = 6,
    parameter int               SLOT_BITS = 2,
    parameter int               LBA_W     = 32,
    parameter logic [LBA_W-1:0] BASE_LBA  = '0,
    parameter int               TMO_W     = 20,
    parameter int               MAX_RETRY = 3
) (
    input  logic                  clk_sys,
    input  logic                  RESET_n,
    input  logic                  enable,
    input  logic                  load_req,
    input  logic                  save_req,
    input  logic [SLOT_BITS-1:0]  slot,
    input  logic                  abort,
    bk_sector_streamer_if.master  sd,
    output logic [SECT_BITS-1:0]  sector,
    output logic                  busy,
    output logic                  loading,
    output logic                  done,
    output logic                  error
);
    localparam int             RW        = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0]  RETRY_LIM = RW'(MAX_RETRY);

    bk_state_t             state;
    bk_dir_t               dir;
    logic [SLOT_BITS-1:0]  slot_l;
    logic [RW-1:0]         retry;
    logic                  ld_q, ld_d, sv_q, sv_d, ack_q;
    logic                  abort_pend;
    logic                  tmo_exp;
    logic                  ld_rise, sv_rise, ack_rise, ack_fall;

    assign ld_rise  = ld_q & ~ld_d;
    assign sv_rise  = sv_q & ~sv_d;
    assign ack_rise = sd.sd_ack & ~ack_q;
    assign ack_fall = ~sd.sd_ack & ack_q;

    function automatic logic [LBA_W-1:0] lba_of(input logic [SLOT_BITS-1:0] s,
                                                input logic [SECT_BITS-1:0] c);
        return BASE_LBA + LBA_W'({s, c});
    endfunction

    bk_timeout #(.TMO_W(TMO_W)) u_tmo (
        .clk_sys (clk_sys),
        .RESET_n (RESET_n),
        .clr     (state != REQ),
        .en      (state == REQ),
        .expired (tmo_exp)
    );

    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            state      <= IDLE;
            dir        <= DIR_SAVE;
            slot_l     <= '0;
            retry      <= '0;
            ld_q       <= 1'b0;
            ld_d       <= 1'b0;
            sv_q       <= 1'b0;
            sv_d       <= 1'b0;
            ack_q      <= 1'b0;
            abort_pend <= 1'b0;
            sector     <= '0;
            busy       <= 1'b0;
            loading    <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            sd.sd_lba  <= BASE_LBA;
            sd.sd_rd   <= 1'b0;
            sd.sd_wr   <= 1'b0;
        end else begin
            ld_q  <= load_req & enable;
            ld_d  <= ld_q;
            sv_q  <= save_req & enable;
            sv_d  <= sv_q;
            ack_q <= sd.sd_ack;
            done  <= 1'b0;

            case (state)
                IDLE: begin
                    // load wins a same-cycle tie; rises outside IDLE are simply dropped
                    if (ld_rise || sv_rise) begin
                        state      <= REQ;
                        dir        <= ld_rise ? DIR_LOAD : DIR_SAVE;
                        slot_l     <= slot;
                        sector     <= '0;
                        retry      <= '0;
                        abort_pend <= 1'b0;
                        error      <= 1'b0;
                        busy       <= 1'b1;
                        loading    <= ld_rise;
                        sd.sd_lba  <= lba_of(slot, SECT_BITS'(0));
                        sd.sd_rd   <= ld_rise;
                        sd.sd_wr   <= ~ld_rise;
                    end
                end

                REQ: begin
                    if (abort || ack_rise || tmo_exp) begin
                        sd.sd_rd <= 1'b0;
                        sd.sd_wr <= 1'b0;
                    end
                    if (abort) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        loading <= 1'b0;
                    end else if (ack_rise) begin
                        state <= XFER;
                    end else if (tmo_exp) begin
                        if (retry < RETRY_LIM) begin
                            retry <= retry + RW'(1);
                            state <= GAP;
                        end else begin
                            error   <= 1'b1;
                            state   <= IDLE;
                            busy    <= 1'b0;
                            loading <= 1'b0;
                        end
                    end
                end

                GAP: begin
                    if (abort) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        loading <= 1'b0;
                    end else begin
                        state    <= REQ;
                        sd.sd_rd <= (dir == DIR_LOAD);
                        sd.sd_wr <= (dir == DIR_SAVE);
                    end
                end

                XFER: begin
                    // an abort here only takes effect once hps_io releases the sector
                    if (abort) abort_pend <= 1'b1;
                    if (ack_fall) begin
                        if (abort || abort_pend || (&sector)) begin
                            done    <= ~(abort | abort_pend);
                            state   <= IDLE;
                            busy    <= 1'b0;
                            loading <= 1'b0;
                        end else begin
                            sector    <= sector + SECT_BITS'(1);
                            retry     <= '0;
                            sd.sd_lba <= lba_of(slot_l, sector + SECT_BITS'(1));
                            sd.sd_rd  <= (dir == DIR_LOAD);
                            sd.sd_wr  <= (dir == DIR_SAVE);
                            state     <= REQ;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bk_sector_streamer.sv
// Bench for bk_sector_streamer: table of full operations plus hand sequences for timeout, abort and reset.
module tb_bk_sector_streamer;
    localparam int               SECT_BITS = 6;
    localparam int               SLOT_BITS = 2;
    localparam int               LBA_W     = 32;
    localparam int               TMO_W     = 4;
    localparam int               MAX_RETRY = 2;
    localparam logic [LBA_W-1:0] BASE_LBA  = '0;
    localparam int               NSECT     = 1 << SECT_BITS;

    logic                 clk_sys  = 1'b0;
    logic                 RESET_n  = 1'b0;
    logic                 enable   = 1'b0;
    logic                 load_req = 1'b0;
    logic                 save_req = 1'b0;
    logic                 abort    = 1'b0;
    logic [SLOT_BITS-1:0] slot     = '0;
    logic [SECT_BITS-1:0] sector;
    logic                 busy, loading, done, error;

    bk_sector_streamer_if #(.LBA_W(LBA_W)) sd_if ();

    bk_sector_streamer #(
        .SECT_BITS (SECT_BITS),
        .SLOT_BITS (SLOT_BITS),
        .LBA_W     (LBA_W),
        .BASE_LBA  (BASE_LBA),
        .TMO_W     (TMO_W),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk_sys  (clk_sys),
        .RESET_n  (RESET_n),
        .enable   (enable),
        .load_req (load_req),
        .save_req (save_req),
        .slot     (slot),
        .abort    (abort),
        .sd       (sd_if),
        .sector   (sector),
        .busy     (busy),
        .loading  (loading),
        .done     (done),
        .error    (error)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic             rd;
        logic [LBA_W-1:0] lba;
    } exp_t;

    typedef struct {
        logic                 ld;
        logic                 sv;
        logic                 en;
        logic [SLOT_BITS-1:0] slot;
        logic                 mid;
        logic                 exp_run;
        logic                 exp_load;
    } vec_t;

    exp_t             sb[$];
    vec_t             vecs[5];
    int               total = 0, bad = 0, cyc = 0, cur_vec = 0;
    int               done_cnt = 0, load_viol = 0, last_fall = 0;
    logic             exp_load_now = 1'b0, noack_on = 1'b0;
    logic [LBA_W-1:0] noack_lba = '0;
    logic             prev_req = 1'b0, prev_ack = 1'b0;
    int               n, hi, lo, d0;
    bit               busy_ok;

    function automatic logic [LBA_W-1:0] exp_lba(input int sl, input int sc);
        return BASE_LBA + LBA_W'(sl * NSECT + sc);
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s (step %0d): got %0d required %0d", nm, cur_vec, act, req);
        end
    endtask

    task automatic push_op(input logic ld, input int sl, input int nsec);
        for (int s = 0; s < nsec; s++) sb.push_back('{rd: ld, lba: exp_lba(sl, s)});
    endtask

    task automatic issue(input logic ld, input logic sv, input logic [SLOT_BITS-1:0] sl);
        @(posedge clk_sys); #1;
        load_req = ld;
        save_req = sv;
        slot     = sl;
        repeat (3) @(negedge clk_sys);
        load_req = 1'b0;
        save_req = 1'b0;
    endtask

    always @(posedge clk_sys) cyc++;

    // scoreboard monitor: every new rd/wr request must match the next expected sector
    always @(negedge clk_sys) begin
        exp_t e;
        logic cur_req;
        cur_req = sd_if.sd_rd | sd_if.sd_wr;
        if (cur_req && !prev_req) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_req (step %0d): got lba %0d required no request", cur_vec, sd_if.sd_lba);
            end else begin
                e = sb.pop_front();
                check("req_lba", 64'(sd_if.sd_lba), 64'(e.lba));
                check("req_dir", 64'({sd_if.sd_rd, sd_if.sd_wr}), 64'({e.rd, ~e.rd}));
            end
        end
        prev_req = cur_req;
        if (prev_ack && !sd_if.sd_ack) last_fall = cyc;
        prev_ack = sd_if.sd_ack;
        if (done) begin
            done_cnt++;
            check("done_latency", 64'(cyc - last_fall), 64'd1);
        end
        if (loading !== (busy & exp_load_now)) load_viol++;
    end

    // hps_io model: acks a request one cycle after seeing it, holds ack for 3 cycles
    initial begin
        sd_if.sd_ack = 1'b0;
        forever begin
            @(negedge clk_sys);
            if ((sd_if.sd_rd || sd_if.sd_wr) && !(noack_on && sd_if.sd_lba == noack_lba)) begin
                @(posedge clk_sys); #1;
                if (sd_if.sd_rd || sd_if.sd_wr) begin
                    sd_if.sd_ack = 1'b1;
                    repeat (3) @(posedge clk_sys);
                    #1 sd_if.sd_ack = 1'b0;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic run_vec(input vec_t v);
        int lat, k, v0;
        bit bok;
        v0 = done_cnt;
        exp_load_now = v.exp_load;
        if (v.exp_run) push_op(v.exp_load, int'(v.slot), NSECT);
        @(posedge clk_sys); #1;
        load_req = v.ld;
        save_req = v.sv;
        enable   = v.en;
        slot     = v.slot;
        lat = -1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_sys);
            if (c == 3) begin
                load_req = 1'b0;
                save_req = 1'b0;
            end
            if ((sd_if.sd_rd || sd_if.sd_wr) && lat < 0) lat = c;
        end
        enable = 1'b1;
        check("start_latency", 64'(lat), 64'(v.exp_run ? 2 : -1));
        if (v.exp_run) begin
            bok = 1'b1;
            k = 0;
            while (!done && k < 3000) begin
                @(negedge clk_sys);
                if (!done && !busy) bok = 1'b0;
                if (v.mid && k == 40) begin
                    load_req = 1'b1;
                    save_req = 1'b1;
                end
                if (v.mid && k == 44) begin
                    load_req = 1'b0;
                    save_req = 1'b0;
                end
                k++;
            end
            repeat (3) @(negedge clk_sys);
            check("done_count", 64'(done_cnt - v0), 64'd1);
            check("busy_through", 64'(bok), 64'd1);
            check("busy_after", 64'(busy), 64'd0);
            check("error_after", 64'(error), 64'd0);
        end else begin
            check("idle_busy", 64'(busy), 64'd0);
            check("idle_done", 64'(done_cnt - v0), 64'd0);
        end
        check("sb_drained", 64'(sb.size()), 64'd0);
        check("loading_track", 64'(load_viol), 64'd0);
        load_viol = 0;
    endtask

    initial begin
        vecs[0] = '{ld: 1'b0, sv: 1'b1, en: 1'b1, slot: 2'd2, mid: 1'b1, exp_run: 1'b1, exp_load: 1'b0};
        vecs[1] = '{ld: 1'b1, sv: 1'b1, en: 1'b1, slot: 2'd1, mid: 1'b0, exp_run: 1'b1, exp_load: 1'b1};
        vecs[2] = '{ld: 1'b1, sv: 1'b0, en: 1'b0, slot: 2'd3, mid: 1'b0, exp_run: 1'b0, exp_load: 1'b0};
        vecs[3] = '{ld: 1'b1, sv: 1'b0, en: 1'b1, slot: 2'd3, mid: 1'b0, exp_run: 1'b1, exp_load: 1'b1};
        vecs[4] = '{ld: 1'b0, sv: 1'b1, en: 1'b1, slot: 2'd0, mid: 1'b0, exp_run: 1'b1, exp_load: 1'b0};

        enable = 1'b1;
        repeat (3) @(negedge clk_sys);
        check("reset_flags", 64'({sd_if.sd_rd, sd_if.sd_wr, busy, loading, done, error}), 64'd0);
        check("reset_sector", 64'(sector), 64'd0);
        check("reset_lba", 64'(sd_if.sd_lba), 64'(BASE_LBA));
        RESET_n = 1'b1;
        @(negedge clk_sys);

        for (int i = 0; i < 5; i++) begin
            cur_vec = i;
            run_vec(vecs[i]);
        end

        // no ack on sector 5: three 15-cycle attempts separated by one-cycle gaps, then error
        cur_vec = 10;
        exp_load_now = 1'b1;
        d0 = done_cnt;
        noack_lba = exp_lba(0, 5);
        noack_on = 1'b1;
        push_op(1'b1, 0, 5);
        repeat (3) sb.push_back('{rd: 1'b1, lba: exp_lba(0, 5)});
        issue(1'b1, 1'b0, 2'd0);
        n = 0;
        while (!(sd_if.sd_rd && sd_if.sd_lba == noack_lba) && n < 300) begin
            @(negedge clk_sys);
            n++;
        end
        for (int a = 0; a < 3; a++) begin
            hi = 0;
            while (sd_if.sd_rd && hi < 40) begin
                hi++;
                @(negedge clk_sys);
            end
            check("tmo_rd_len", 64'(hi), 64'd15);
            if (a < 2) begin
                lo = 0;
                while (!sd_if.sd_rd && lo < 10) begin
                    lo++;
                    @(negedge clk_sys);
                end
                check("tmo_gap_len", 64'(lo), 64'd1);
            end
        end
        check("tmo_error", 64'(error), 64'd1);
        check("tmo_busy", 64'(busy), 64'd0);
        noack_on = 1'b0;
        repeat (5) @(negedge clk_sys);
        check("tmo_no_done", 64'(done_cnt - d0), 64'd0);
        check("tmo_sb", 64'(sb.size()), 64'd0);

        // next request clears error; abort while requesting sector 3
        cur_vec = 11;
        exp_load_now = 1'b0;
        d0 = done_cnt;
        push_op(1'b0, 3, 4);
        issue(1'b0, 1'b1, 2'd3);
        check("err_cleared", 64'(error), 64'd0);
        check("busy_start", 64'(busy), 64'd1);
        n = 0;
        while (!(sd_if.sd_wr && sd_if.sd_lba == exp_lba(3, 3)) && n < 300) begin
            @(negedge clk_sys);
            n++;
        end
        abort = 1'b1;
        @(negedge clk_sys);
        abort = 1'b0;
        check("abort_req_wr", 64'(sd_if.sd_wr), 64'd0);
        check("abort_req_busy", 64'(busy), 64'd0);
        repeat (10) @(negedge clk_sys);
        check("abort_req_done", 64'(done_cnt - d0), 64'd0);
        check("abort_req_err", 64'(error), 64'd0);
        check("abort_req_sb", 64'(sb.size()), 64'd0);

        // abort during the transfer of sector 7: busy holds until ack falls
        cur_vec = 12;
        exp_load_now = 1'b1;
        d0 = done_cnt;
        push_op(1'b1, 2, 8);
        issue(1'b1, 1'b0, 2'd2);
        n = 0;
        while (!(busy && sd_if.sd_ack && !sd_if.sd_rd && sd_if.sd_lba == exp_lba(2, 7)) && n < 400) begin
            @(negedge clk_sys);
            n++;
        end
        abort = 1'b1;
        @(negedge clk_sys);
        abort = 1'b0;
        busy_ok = 1'b1;
        n = 0;
        while (sd_if.sd_ack && n < 10) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk_sys);
            n++;
        end
        check("xfer_busy_held", 64'(busy_ok & busy), 64'd1);
        @(negedge clk_sys);
        check("xfer_abort_busy", 64'(busy), 64'd0);
        check("xfer_abort_rd", 64'(sd_if.sd_rd), 64'd0);
        repeat (10) @(negedge clk_sys);
        check("xfer_abort_done", 64'(done_cnt - d0), 64'd0);
        check("xfer_abort_sb", 64'(sb.size()), 64'd0);
        check("xfer_loading", 64'(load_viol), 64'd0);
        load_viol = 0;

        // asynchronous reset in the middle of sector 2's transfer
        cur_vec = 13;
        exp_load_now = 1'b0;
        push_op(1'b0, 1, 3);
        issue(1'b0, 1'b1, 2'd1);
        n = 0;
        while (!(busy && sd_if.sd_ack && !sd_if.sd_wr && sd_if.sd_lba == exp_lba(1, 2)) && n < 300) begin
            @(negedge clk_sys);
            n++;
        end
        #2 RESET_n = 1'b0;
        #1;
        check("rst_flags", 64'({sd_if.sd_rd, sd_if.sd_wr, busy, loading, done, error}), 64'd0);
        check("rst_sector", 64'(sector), 64'd0);
        check("rst_lba", 64'(sd_if.sd_lba), 64'(BASE_LBA));
        repeat (6) @(negedge clk_sys);
        check("rst_sb", 64'(sb.size()), 64'd0);
        RESET_n = 1'b1;
        @(negedge clk_sys);
        cur_vec = 14;
        run_vec(vecs[4]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
